// File: rtl/ndma_pkg.sv
// Shared types and constants for the NanoDMA blocks.
//   rd_state_t      : read-manager FSM states
//   NDMA_WORD_BYTES : bytes per bus word (address stride)
//   NDMA_BE_FULL    : byte enable for a full-word access
package ndma_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

    localparam int unsigned NDMA_WORD_BYTES = 4;
    localparam logic [3:0]  NDMA_BE_FULL    = 4'hF;

endpackage

// File: rtl/obi_bus.sv
// Minimal OBI bus bundle (32-bit address/data, single-bit ID and optional fields).
//   Manager     : drives the A channel, receives gnt and the R channel
//   Subordinate : mirror image of Manager
interface OBI_BUS;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport Manager (
        output req, addr, we, be, wdata, aid, a_optional,
        input  gnt, rvalid, rdata, err
    );

    modport Subordinate (
        input  req, addr, we, be, wdata, aid, a_optional,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/ndma_rsp_fifo.sv
// Response FIFO with first-word fall-through from registered storage.
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   push_i, data_i   : write port (ignored when full)
//   pop_i, data_o    : read port; data_o is the head word, 0 when empty
//   full_o, empty_o  : status flags
//   count_o          : number of stored words, 0..Depth
module ndma_rsp_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign wr_en   = push_i & ~full_o;
    assign rd_en   = pop_i & ~empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage needs no reset; empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ndma_read_mgr.sv
// NanoDMA source-side OBI read manager: issues pipelined full-word reads from a
// start address, buffers responses and streams them out in order.
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   start_i           : start pulse (ignored while busy_o)
//   addr_i, len_i     : start byte address (word aligned internally), word count
//   busy_o, done_o    : transfer in progress, one-cycle end pulse
//   err_o             : sticky response error, cleared by the next start
//   data_o, valid_o   : output stream head word / valid
//   ready_i           : output stream ready
//   read_mgr          : OBI manager port (read-only traffic)
module ndma_read_mgr
    import ndma_pkg::*;
#(
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned LenWidth       = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         addr_i,
    input  logic [LenWidth-1:0] len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [31:0]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    OBI_BUS.Manager             read_mgr
);

    localparam int unsigned InfW = $clog2(MaxOutstanding + 1);
    localparam int unsigned OccW = $clog2(FifoDepth + 1);

    rd_state_t           state_q, state_d;
    logic [31:0]         base_q, base_d, addr_q, addr_d;
    logic [LenWidth-1:0] len_q, len_d, issued_q, issued_d, received_q, received_d;
    logic [InfW-1:0]     inflight_q, inflight_d;
    logic                req_q, req_d, err_q, err_d, done_q, done_d;

    logic [OccW-1:0]     occupancy;
    logic [31:0]         occ_nxt, start_base;
    logic                gnt_fire, rsp_fire, fifo_push, pop, fifo_full, fifo_empty;
    logic                can_issue, can_issue_after;

    assign gnt_fire   = req_q & read_mgr.gnt;
    // Responses with nothing in flight (e.g. after a reset) are dropped.
    assign rsp_fire   = read_mgr.rvalid & (inflight_q != '0);
    assign fifo_push  = rsp_fire & ~fifo_full;
    assign pop        = valid_o & ready_i;
    assign occ_nxt    = 32'(occupancy) + 32'(fifo_push) - 32'(pop);
    assign start_base = addr_i & ~32'(NDMA_WORD_BYTES - 1);

    // Credit rule: every in-flight or pending read owns a FIFO slot.
    assign can_issue = (issued_q < len_q)
                     && (32'(inflight_q) < MaxOutstanding)
                     && (32'(inflight_q) + 32'(occupancy) + 32'(req_q) < FifoDepth);

    // Re-evaluated in a grant cycle to allow back-to-back requests; the
    // granted read still counts against credits, a same-cycle pop does not.
    assign can_issue_after = (issued_d < len_q)
                           && (32'(inflight_d) < MaxOutstanding)
                           && (32'(inflight_q) + 32'd1 + 32'(occupancy) < FifoDepth);

    ndma_rsp_fifo #(
        .Depth (FifoDepth),
        .Width (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (read_mgr.rdata),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        issued_d   = issued_q;
        received_d = received_q;
        inflight_d = inflight_q;
        req_d      = req_q;
        addr_d     = addr_q;
        err_d      = err_q;
        done_d     = 1'b0;

        if (gnt_fire) issued_d = issued_q + 1'b1;
        if (rsp_fire) begin
            received_d = received_q + 1'b1;
            if (read_mgr.err) err_d = 1'b1;
        end
        case ({gnt_fire, rsp_fire})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        unique case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (start_i) begin
                    err_d      = 1'b0;
                    issued_d   = '0;
                    received_d = '0;
                    inflight_d = '0;
                    if (len_i != '0) begin
                        state_d = ISSUE;
                        base_d  = start_base;
                        len_d   = len_i;
                        // First request needs no credit check: everything is empty.
                        req_d   = 1'b1;
                        addr_d  = start_base;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (gnt_fire) begin
                    req_d  = can_issue_after;
                    addr_d = base_q + 32'(issued_d) * NDMA_WORD_BYTES;
                    if (issued_d == len_q) state_d = DRAIN;
                end else if (!req_q && can_issue) begin
                    req_d  = 1'b1;
                    addr_d = base_q + 32'(issued_q) * NDMA_WORD_BYTES;
                end
            end
            DRAIN: begin
                if ((received_d == len_q) && (occ_nxt == 32'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            inflight_q <= '0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            inflight_q <= inflight_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign valid_o = ~fifo_empty;

    assign read_mgr.req        = req_q;
    assign read_mgr.addr       = addr_q;
    assign read_mgr.we         = 1'b0;
    assign read_mgr.be         = NDMA_BE_FULL;
    assign read_mgr.wdata      = '0;
    assign read_mgr.aid        = 1'b0;
    assign read_mgr.a_optional = 1'b0;

endmodule

// File: tb/tb_ndma_read_mgr.sv
// Self-checking bench for ndma_read_mgr: OBI subordinate model, stream
// consumer with optional backpressure, table of transfer vectors plus
// hand-written latency, zero-length, reset and wrap sequences.
module tb_ndma_read_mgr;

    localparam int unsigned FifoDepth = 4;
    localparam int unsigned MaxOut    = 2;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          stall_idx;   // request index whose grant is delayed
        int          stall_cyc;
        int          bp;          // cycles of ready_i=0 after start
        int          err_idx;     // response index returned with err=1
        logic        exp_err;
        logic [31:0] exp_last;    // hand-computed address of the last request
        int          exp_gnt_bp;  // grants expected when backpressure ends
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr_in = '0;
    logic [15:0] len_in = '0;
    logic        ready = 1'b0;
    logic        busy, done, err, valid;
    logic [31:0] data;

    OBI_BUS obi ();

    always #5 clk = ~clk;

    ndma_read_mgr #(
        .FifoDepth      (FifoDepth),
        .MaxOutstanding (MaxOut),
        .LenWidth       (16)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .addr_i   (addr_in),
        .len_i    (len_in),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .data_o   (data),
        .valid_o  (valid),
        .ready_i  (ready),
        .read_mgr (obi)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // model state
    logic [31:0] m_base = '0;
    logic [31:0] last_hs_addr = '0;
    logic [31:0] l_addr = '0;
    logic [31:0] pend [$];
    int c_stall_idx = -1, c_stall_cyc = 0, c_bp = 0, c_err_idx = -1;
    int hs_cnt = 0, rsp_cnt = 0, pop_cnt = 0, outstanding = 0, max_out = 0;
    int stall_left = 0, bp_left = 0;
    logic l_req = 0, l_gnt = 0, l_rv_cnt = 0, l_err = 0, l_valid = 0, l_ready = 0;
    logic err_exp = 0, chk_en = 0, inject = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEADAEEF;
    endfunction

    // Advance one cycle; inputs are driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        logic        s_start, s_busy;
        logic [31:0] s_addr, a;
        int          occ;
        s_start = start;
        s_busy  = busy;
        s_addr  = addr_in;
        @(posedge clk);
        #2;
        if (!rst_n) begin
            pend.delete();
            hs_cnt = 0; rsp_cnt = 0; pop_cnt = 0; outstanding = 0; err_exp = 0;
            obi.gnt = 0; obi.rvalid = 0; obi.err = 0; obi.rdata = '0;
            l_req = 0; l_gnt = 0; l_rv_cnt = 0; l_err = 0; l_valid = 0; l_ready = 0;
            return;
        end
        if (s_start && !s_busy) begin
            m_base = s_addr & ~32'h3;
            hs_cnt = 0; rsp_cnt = 0; pop_cnt = 0; outstanding = 0; max_out = 0;
            err_exp = 0; stall_left = c_stall_cyc; bp_left = c_bp;
        end
        if (l_req && l_gnt) begin
            a = m_base + 32'(hs_cnt) * 32'd4;
            chk("gnt_addr", l_addr, a);
            pend.push_back(l_addr);
            last_hs_addr = l_addr;
            hs_cnt++;
            outstanding++;
        end
        if (l_rv_cnt) begin
            outstanding--;
            rsp_cnt++;
            if (l_err) err_exp = 1;
        end
        if (l_valid && l_ready) pop_cnt++;
        if (outstanding > max_out) max_out = outstanding;
        occ = rsp_cnt - pop_cnt;
        if (chk_en) begin
            chk("valid_o", valid, occ != 0);
            if (occ != 0) chk("data_o", data, word(m_base + 32'(pop_cnt) * 32'd4));
            chk("err_o", err, err_exp);
            chk("credit", (outstanding + occ) <= FifoDepth, 1);
            if (l_req && !l_gnt) begin
                chk("req_hold", obi.req, 1);
                chk("addr_hold", obi.addr, l_addr);
            end
        end
        // drive this cycle
        obi.rvalid = 0; obi.err = 0; obi.rdata = '0; l_rv_cnt = 0;
        if (inject) begin
            obi.rvalid = 1;
            obi.rdata  = 32'hBAD0BAD0;
            inject     = 0;
        end else if (pend.size() > 0) begin
            a = pend.pop_front();
            obi.rvalid = 1;
            obi.rdata  = word(a);
            obi.err    = (rsp_cnt == c_err_idx);
            l_rv_cnt   = 1;
        end
        if (obi.req && hs_cnt == c_stall_idx && stall_left > 0) begin
            obi.gnt = 0;
            stall_left--;
        end else begin
            obi.gnt = obi.req;
        end
        ready = (bp_left == 0);
        if (bp_left > 0) bp_left--;
        l_req = obi.req; l_gnt = obi.gnt; l_addr = obi.addr; l_err = obi.err;
        l_valid = valid; l_ready = ready;
    endtask

    task automatic run_xfer(input int id, input xfer_t r);
        int cyc;
        bit seen;
        c_stall_idx = r.stall_idx; c_stall_cyc = r.stall_cyc;
        c_bp = r.bp; c_err_idx = r.err_idx;
        addr_in = r.addr;
        len_in  = 16'(r.len);
        start   = 1;
        tick();
        start = 0;
        cyc = 0;
        seen = 0;
        while (cyc < 300 && !seen) begin
            if (r.bp > 0 && cyc == r.bp)
                chk($sformatf("vec%0d.bp_grants", id), hs_cnt, r.exp_gnt_bp);
            tick();
            cyc++;
            if (done) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL vec%0d.timeout: done_o=0 after %0d cycles, required done_o=1", id, cyc);
        end
        chk($sformatf("vec%0d.busy_at_done", id), busy, 0);
        chk($sformatf("vec%0d.grants", id), hs_cnt, r.len);
        chk($sformatf("vec%0d.words", id), pop_cnt, r.len);
        chk($sformatf("vec%0d.last_addr", id), last_hs_addr, r.exp_last);
        chk($sformatf("vec%0d.err_end", id), err, r.exp_err);
        chk($sformatf("vec%0d.max_inflight_ok", id), max_out <= MaxOut, 1);
        tick();
        chk($sformatf("vec%0d.done_pulse", id), done, 0);
        chk($sformatf("vec%0d.valid_after", id), valid, 0);
    endtask

    xfer_t tbl [4];
    xfer_t wrap_v;

    initial begin
        obi.gnt = 0; obi.rvalid = 0; obi.rdata = '0; obi.err = 0;

        tbl[0] = '{32'h0000_2002, 8, -1, 0, 0, -1, 1'b0, 32'h0000_201C, 0};
        tbl[1] = '{32'h0000_3000, 6, -1, 0, 10, -1, 1'b0, 32'h0000_3014, 4};
        tbl[2] = '{32'h0000_4000, 4, 1, 5, 0, -1, 1'b0, 32'h0000_400C, 0};
        tbl[3] = '{32'h0000_5000, 3, -1, 0, 0, 1, 1'b1, 32'h0000_5008, 0};
        wrap_v = '{32'hFFFF_FFF8, 4, -1, 0, 0, -1, 1'b0, 32'h0000_0004, 0};

        // reset state
        rst_n = 0;
        repeat (3) tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.valid", valid, 0);
        chk("rst.data", data, 0);
        chk("rst.req", obi.req, 0);
        chk("rst.addr", obi.addr, 0);
        chk("rst.err", err, 0);
        chk("tie.we", obi.we, 0);
        chk("tie.be", obi.be, 32'hF);
        chk("tie.wdata", obi.wdata, 0);
        rst_n  = 1;
        chk_en = 1;
        tick();

        // single word, latency profile
        c_stall_idx = -1; c_stall_cyc = 0; c_bp = 0; c_err_idx = -1;
        addr_in = 32'h0000_1000;
        len_in  = 16'd1;
        start   = 1;
        tick();
        start = 0;
        chk("single.req_c1", obi.req, 1);
        chk("single.addr_c1", obi.addr, 32'h0000_1000);
        chk("single.we_c1", obi.we, 0);
        chk("single.busy_c1", busy, 1);
        tick();
        chk("single.valid_c2", valid, 0);
        chk("single.req_c2", obi.req, 0);
        tick();
        chk("single.valid_c3", valid, 1);
        chk("single.data_c3", data, 32'hDEAD_BEEF);
        tick();
        chk("single.done_c4", done, 1);
        chk("single.busy_c4", busy, 0);
        tick();
        chk("single.done_c5", done, 0);

        for (int i = 0; i < 4; i++) run_xfer(i, tbl[i]);

        // zero length right after the error transfer: clears err_o, no traffic
        c_stall_idx = -1; c_stall_cyc = 0; c_bp = 0; c_err_idx = -1;
        addr_in = 32'h0000_7000;
        len_in  = 16'd0;
        start   = 1;
        tick();
        start = 0;
        chk("zero.done", done, 1);
        chk("zero.busy", busy, 0);
        chk("zero.req", obi.req, 0);
        chk("zero.err_cleared", err, 0);
        tick();
        chk("zero.done_pulse", done, 0);
        chk("zero.req_after", obi.req, 0);

        // reset in the middle of a burst, then a late response
        addr_in = 32'h0000_6000;
        len_in  = 16'd8;
        start   = 1;
        tick();
        start = 0;
        repeat (3) tick();
        chk("midrst.busy_before", busy, 1);
        rst_n = 0;
        tick();
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.valid", valid, 0);
        chk("midrst.data", data, 0);
        chk("midrst.req", obi.req, 0);
        chk("midrst.addr", obi.addr, 0);
        chk("midrst.err", err, 0);
        rst_n  = 1;
        inject = 1;
        tick();
        tick();
        chk("late.valid", valid, 0);
        chk("late.busy", busy, 0);
        tick();
        chk("late.valid2", valid, 0);

        // address wrap past 2^32
        run_xfer(4, wrap_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
